// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - multi-digit BCD modulo counter, range MIN..MAX, up/down, load, wrap pulses
// Optional COUNT_PM_EN adds the pm output that toggles on every wrap.
module bcd_mod_counter #(
  parameter int DIGITS = 2,
  parameter int MIN    = 0,
  parameter int MAX    = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
`ifdef COUNT_PM_EN
  ,
  output logic                  pm
`endif
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX);

  if (!(MIN >= 0 && MIN <= MAX && MAX < 10 ** DIGITS)) begin : g_bad_cfg
    $error("bcd_mod_counter: illegal MIN/MAX/DIGITS configuration");
  end

  logic [W-1:0] q_q, q_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;
  logic         load_err_q, load_err_d;
`ifdef COUNT_PM_EN
  logic         pm_q, pm_d;
`endif

  logic [W-1:0] inc_val, dec_val;
  logic         inc_c, dec_b, digits_ok;
  logic [W:0]   below_min, above_max;

  always_comb begin
    inc_val   = q_q;
    dec_val   = q_q;
    inc_c     = 1'b1;
    dec_b     = 1'b1;
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (inc_c) begin
        if (q_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
      if (load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    // With valid digits, BCD ordering equals numeric ordering; sign bit of the difference flags out-of-range.
    below_min = {1'b0, load_val} - {1'b0, MIN_BCD};
    above_max = {1'b0, MAX_BCD} - {1'b0, load_val};
  end

  always_comb begin
    q_d        = q_q;
    carry_d    = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (digits_ok && !below_min[W] && !above_max[W]) begin
        q_d = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (q_q == MAX_BCD) begin
          q_d     = MIN_BCD;
          carry_d = 1'b1;
        end else begin
          q_d = inc_val;
        end
      end else begin
        if (q_q == MIN_BCD) begin
          q_d      = MAX_BCD;
          borrow_d = 1'b1;
        end else begin
          q_d = dec_val;
        end
      end
    end
`ifdef COUNT_PM_EN
    pm_d = pm_q ^ (carry_d | borrow_d);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= MIN_BCD;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
`ifdef COUNT_PM_EN
      pm_q       <= 1'b0;
`endif
    end else begin
      q_q        <= q_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
`ifdef COUNT_PM_EN
      pm_q       <= pm_d;
`endif
    end
  end

  assign q        = q_q;
  assign carry    = carry_q;
  assign borrow   = borrow_q;
  assign load_err = load_err_q;
`ifdef COUNT_PM_EN
  assign pm       = pm_q;
`endif

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
- Parametrised multi-digit BCD modulo counter with a programmable count range (MIN..MAX), up/down direction, synchronous parallel load, and one-cycle wrap pulses.
- Successor to the fixed 0-to-11 hour counter. One instance covers 12-hour (1..12), 24-hour (0..23) and minute/second (0..59) fields of the clock.
- Sits between the 1 Hz tick generator / lower-field carry and the seven-segment display mux. The set-time logic drives the load path.

Parameters:
- DIGITS, 2, number of BCD digits; q width is 4*DIGITS.
- MIN, 0, lowest count value (decimal integer); reset value.
- MAX, 11, highest count value (decimal integer). Legal configuration: 0 <= MIN <= MAX < 10**DIGITS; anything else is a static configuration error.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- en  in  1  count enable (tick or lower-field carry); sampled each clk edge.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel-load strobe.
- load_val  in  4*DIGITS  BCD value to load.
- q  out  4*DIGITS  current count, BCD, most significant digit in top nibble.
- carry  out  1  one-cycle pulse on up-wrap MAX->MIN.
- borrow  out  1  one-cycle pulse on down-wrap MIN->MAX.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- All outputs are registered and change only on the rising edge of clk.
- Priority per edge: reset > load > en. Inputs are ignored when none of them is active.
- Reset: q = BCD(MIN), carry = 0, borrow = 0, load_err = 0 on the next edge. Applies mid-count and during load; the load is discarded.
- Load accept: every nibble of load_val is <= 9 and the decimal value is within MIN..MAX. Then q = load_val next edge, and carry/borrow/load_err = 0.
- Load reject: any nibble > 9 or value out of range. Then q holds and load_err = 1 for exactly one cycle.
- Load never produces carry/borrow. en is ignored in a load cycle.
- Count up (en=1, up=1, no load):
  - q != MAX: q = q+1 in BCD. A digit at 9 becomes 0 and propagates +1 to the next digit.
  - q == MAX: q = BCD(MIN) and carry = 1.
- Count down (en=1, up=0, no load):
  - q != MIN: q = q-1 in BCD. A digit at 0 becomes 9 and borrows from the next digit.
  - q == MIN: q = BCD(MAX) and borrow = 1.
- carry/borrow are high exactly in the cycle in which q first shows the wrapped value, i.e. zero lag relative to q. Otherwise 0.
- Latency: a single edge from en/load sample to q update.
- en held high continuously: period of MAX-MIN+1 cycles, one carry per period.
- MIN == MAX: q is constant, and every enabled cycle pulses carry (up) or borrow (down).
- Direction may change on any cycle; the new direction applies from that edge.
- q never holds a non-BCD nibble or an out-of-range value in any reachable state.

Optional Feature:
- Macro COUNT_PM_EN.
- Defined: adds output port pm (1 bit, registered, reset 0). pm toggles on every edge that asserts carry or borrow. Load does not change pm.
- Undefined: port pm does not exist; behaviour otherwise identical.

Test Plan:
- DIGITS=2, MIN=1, MAX=12; assert reset 1 cycle -> q=8'h01, carry=0, borrow=0, load_err=0.
- Same config, up=1, en=1 for 12 cycles from 8'h01 -> q steps 02..09,10,11,12,01. The 09->10 step is BCD (no 0A). carry=1 only in the cycle q returns to 01.
- From q=8'h01, up=0, en=1 for 1 cycle -> q=8'h12, borrow=1 for one cycle. 2 more cycles -> q=8'h11, then 8'h10.
- load_val=8'h09 -> q=8'h09, load_err=0. load_val=8'h13 (out of range) -> q stays 09, load_err=1 one cycle. load_val=8'h1A (non-BCD) -> same rejection.
- q=8'h12, en=1, up=1 and load=1 with 8'h05 on the same edge -> q=8'h05, carry=0. reset=1 together with load -> q=8'h01.
- DIGITS=2, MIN=0, MAX=59 with COUNT_PM_EN defined: 60 enabled up cycles from 00 -> q back at 00, carry once, pm 0->1. One down cycle -> q=8'h59, borrow=1, pm 1->0.
